// File: rtl/mult16_seq_pkg.sv
// Shared constants for the sequential 16x16 multiplier: state encodings,
// operand width and iteration count.
package mult16_defs;

    typedef logic [1:0] mult16_state_t;

    localparam mult16_state_t IDLE = 2'd0;
    localparam mult16_state_t RUN  = 2'd1;
    localparam mult16_state_t DONE = 2'd2;

    localparam int MULT16_W    = 16;
    localparam int MULT16_ITER = 16;

endpackage

// File: rtl/mult16_seq_if.sv
// Request/response bundle for mult16_seq: start plus operands in,
// busy/done status and the 32-bit product out.
interface mult16_seq_if
    import mult16_defs::*;
;
    logic                      start;
    logic [MULT16_W-1:0]       a;
    logic [MULT16_W-1:0]       b;
    logic                      busy;
    logic                      done;
    logic [2*MULT16_W-1:0]     prod;

    modport master (output start, a, b, input busy, done, prod);
    modport slave  (input start, a, b, output busy, done, prod);
endinterface

// File: rtl/mult16_seq_cla.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups whose group
// generate/propagate terms feed a second lookahead level for group carries.
module cla_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        CI,
    output logic [15:0] S,
    output logic        CO
);
    logic [3:0] w_gg;
    logic [3:0] w_gp;
    logic [4:0] w_gc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            logic [3:0] w_g;
            logic [3:0] w_p;
            logic [3:0] w_c;
            assign w_g = A[gi*4 +: 4] & B[gi*4 +: 4];
            assign w_p = A[gi*4 +: 4] ^ B[gi*4 +: 4];
            assign w_c[0] = w_gc[gi];
            assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
            assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
            assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                          | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
            assign S[gi*4 +: 4] = w_p ^ w_c;
            assign w_gg[gi] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
            assign w_gp[gi] = &w_p;
        end
    endgenerate

    // Second-level lookahead: group carries straight from CI and group G/P.
    assign w_gc[0] = CI;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & CI);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & CI);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & CI);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & CI);
    assign CO = w_gc[4];
endmodule

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier sharing one CLA over
// 16 iterations; 17 cycles from accepting start to the done pulse.
// Optional: define MULT16_ZERO_SKIP_EN to finish zero-operand requests
// straight into DONE without running the iterations.
module mult16_seq
    import mult16_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    mult16_seq_if.slave bus
);
    mult16_state_t          r_state;
    logic [MULT16_W-1:0]    r_mcand;
    logic [2*MULT16_W-1:0]  r_acc;
    logic [2*MULT16_W-1:0]  r_prod;
    logic [4:0]             r_cnt;

    logic [MULT16_W-1:0]    w_sum;
    logic                   w_co;
    logic [MULT16_W:0]      w_step;
    logic [2*MULT16_W-1:0]  w_acc_next;
    logic                   w_accept;
    logic                   w_zero;

    cla_16bit u_cla (
        .A  (r_acc[31:16]),
        .B  (r_mcand),
        .CI (1'b0),
        .S  (w_sum),
        .CO (w_co)
    );

    // Add the multiplicand into the high half only when the current
    // multiplier bit is set; the carry becomes the new top bit after shifting.
    assign w_step     = r_acc[0] ? {w_co, w_sum} : {1'b0, r_acc[31:16]};
    assign w_acc_next = {w_step, r_acc[15:1]};
    assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));

`ifdef MULT16_ZERO_SKIP_EN
    assign w_zero = (bus.a == '0) || (bus.b == '0);
`else
    assign w_zero = 1'b0;
`endif

    // FSM, iteration counter and shift-accumulate register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MULT16_ITER - 1)) begin
                        r_state <= DONE;
                        r_prod  <= w_acc_next;
                    end
                end
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_mcand <= bus.a;
                        r_acc   <= {16'h0, bus.b};
                        r_cnt   <= '0;
                        if (w_zero) begin
                            r_state <= DONE;
                            r_prod  <= '0;
                        end else begin
                            r_state <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.prod = r_prod;
endmodule

// File: tb/tb_mult16_seq.sv
// Scoreboard bench for mult16_seq: stimulus pushes expected product, done
// cycle and busy-cycle count; a monitor pops and compares on each done.
module tb_mult16_seq;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   busy_cnt;

    typedef struct {
        logic [31:0] prod;
        int          cyc;
        int          busy;
    } exp_t;

    exp_t sb[$];

    mult16_seq_if bus ();

    mult16_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef MULT16_ZERO_SKIP_EN
    localparam int ZERO_LAT  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_LAT  = 17;
    localparam int ZERO_BUSY = 16;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one pop per done cycle.
    initial begin
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else if (bus.done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("prod", bus.prod, e.prod);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                    check("busy_in_done", {31'h0, bus.busy}, 32'h0);
                    $display("op done: prod=%h cycle=%0d busy_cycles=%0d", bus.prod, cyc, busy_cnt);
                end
                busy_cnt = 0;
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
    end

    // Issue one request at the current negedge and push its expectation.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p, input int lat, input int bsy);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        e.prod = p;
        e.cyc  = cyc + lat;
        e.busy = bsy;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
        @(negedge clk);
        issue(a, b, p, 17, 16);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        repeat (18) @(negedge clk);
    endtask

    logic [15:0] va [6] = '{16'd3,  16'hFFFF, 16'hABCD, 16'd1,    16'h8000, 16'd1};
    logic [15:0] vb [6] = '{16'd5,  16'hFFFF, 16'h1234, 16'hFFFF, 16'd2,    16'd1};
    logic [31:0] vp [6] = '{32'h0000000F, 32'hFFFE0001, 32'h0C374FA4,
                            32'h0000FFFF, 32'h00010000, 32'h00000001};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_prod", bus.prod, 32'h0);
        rst = 1'b0;

        // Directed vectors, one at a time.
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vp[i]);
            check("prod_hold", bus.prod, vp[i]);
        end

        // Start ignored while busy.
        @(negedge clk);
        issue(16'h1234, 16'h0002, 32'h00002468, 17, 16);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.a = 16'd7;
        bus.b = 16'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (25) @(negedge clk);
        check("ignored_prod", bus.prod, 32'h00002468);

        // Back-to-back using the DONE-cycle restart.
        @(negedge clk);
        issue(16'd2, 16'd3, 32'd6, 17, 16);
        repeat (17) @(negedge clk);
        issue(16'd4, 16'd5, 32'd20, 17, 16);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        // Reset mid-run aborts; release with start already high.
        @(negedge clk);
        bus.a = 16'd100;
        bus.b = 16'd100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_done", {31'h0, bus.done}, 32'h0);
        check("abort_prod", bus.prod, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        issue(16'd100, 16'd100, 32'h00002710, 17, 16);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        // Zero operand.
        @(negedge clk);
        issue(16'd0, 16'h1234, 32'h0, ZERO_LAT, ZERO_BUSY);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        check("pending_ops", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult16_seq.md
# mult16_seq

Sequential 16x16 unsigned shift-add multiplier that time-shares one 16-bit carry-lookahead adder over 16 iterations. It provides the multi-cycle MUL path beside the single-cycle ALU. Operands are captured on a start pulse, and the block reports busy until it delivers a 32-bit product with a one-cycle done pulse.

## Interface
Parameters:
- none; width (16) and iteration count (16) are fixed constants.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- a  in  16  multiplicand; captured on the accepting edge.
- b  in  16  multiplier; captured on the accepting edge.
- busy  out  1  high in RUN; low in IDLE and DONE.
- done  out  1  one-cycle pulse, high only in DONE.
- prod  out  32  product register; holds its value until the next accept or reset.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - mcand[15:0]: captured a.
  - acc[31:0]: hi = acc[31:16], lo = acc[15:0].
  - cnt[4:0]: iteration counter.
- Accept: start=1 in IDLE or DONE loads mcand=a, acc={16'h0, b}, cnt=0 and moves to RUN.
- RUN iteration, one per cycle:
  - If acc[0]=1: {c, s} = hi + mcand, using the adder with carry-in 0. Otherwise {c, s} = {0, hi}.
  - acc <= {c, s, lo[15:1]} (a 33-bit value shifted right by 1).
  - cnt <= cnt+1.
- After the 16th iteration (cnt==15 on the edge), the FSM goes to DONE and copies acc to prod.
- DONE with start=0 returns to IDLE.
- DONE with start=1 accepts a new operation directly, so DONE goes straight to RUN.
- start in RUN is ignored; there is no queueing and no error flag.
- Changes to a and b after the accepting edge have no effect.
- Arithmetic is unsigned only. The carry-out of each add is kept as the new acc[31], so the product cannot overflow 32 bits.

## Timing
- Reset (asynchronous, no clock needed) forces:
  - state=IDLE, busy=0, done=0, prod=32'h0.
  - acc, mcand, cnt all 0.
- Edge E0 samples start. busy is high from E0 to E16.
- Edge E16 enters DONE: done=1 and prod is valid in the cycle after E16.
- Latency from start to done is 17 cycles. Sustained throughput is one multiply per 17 cycles using the DONE-cycle restart.
- Reset asserted mid-RUN aborts the operation: no done pulse, prod=0.
- Reset released with start=1 on the first edge: start is accepted normally.

## Configuration
- MULT16_ZERO_SKIP_EN defined:
  - If a==0 or b==0 on the accepting edge, the FSM goes directly to DONE with prod=0.
  - done follows 1 cycle after E0; busy never rises.
- Not defined:
  - All operations take 17 cycles, including zero operands.

## Structure
- Shared header/package mult16_defs holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - MULT16_W=16;
  - MULT16_ITER=16.
- One sub-module: cla_16bit, a 16-bit carry-lookahead adder built from 4-bit lookahead groups.
  - Ports: A[15:0], B[15:0], CI, S[15:0], CO.
  - Instantiated once; the FSM, counter and shift register stay in mult16_seq.

## Test plan
- Basic: a=3, b=5, start for 1 cycle.
  - busy high for 16 cycles; done pulses 17 cycles after start; prod=32'h0000000F.
- Maximum operands: a=16'hFFFF, b=16'hFFFF.
  - prod=32'hFFFE0001 with no carry loss.
- Start ignored while busy:
  - a=16'h1234, b=16'h0002, then start=1 with a=7, b=7 at cycle 5 of RUN.
  - prod=32'h00002468; only one done pulse.
- Back-to-back:
  - start held high with a=2, b=3, then a=4, b=5 presented in the DONE cycle.
  - done pulses at +17 and +34.
  - prod=6, then 20; busy drops only for the DONE cycles.
- Reset mid-op: assert rst at cycle 8 of RUN (a=100, b=100).
  - Immediately busy=0, done=0, prod=0.
  - No done pulse follows; the next start works normally.
- Zero operand: a=0, b=16'h1234.
  - With MULT16_ZERO_SKIP_EN: done 1 cycle after start, busy never rises, prod=0.
  - Without it: done at +17, prod=0.
